// File: rtl/regwen_tracker_pkg.sv
// Shared opcode and control constants for the register-write-enable tracker.
// Also provides the CSR funct3 encodings used to recognise CSRRx instructions.
package regwen_tracker_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_FENCE  = 7'b0001111,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    localparam logic RegWEn_WRITE = 1'b1;
    localparam logic RegWEn_READ  = 1'b0;

    localparam logic [2:0] FUNCT3_CSR_PRIV   = 3'b000;
    localparam logic [2:0] FUNCT3_CSR_CSRRW  = 3'b001;
    localparam logic [2:0] FUNCT3_CSR_CSRRS  = 3'b010;
    localparam logic [2:0] FUNCT3_CSR_CSRRC  = 3'b011;
    localparam logic [2:0] FUNCT3_CSR_CSRRWI = 3'b101;
    localparam logic [2:0] FUNCT3_CSR_CSRRSI = 3'b110;
    localparam logic [2:0] FUNCT3_CSR_CSRRCI = 3'b111;

endpackage

// File: rtl/regwen_tracker_decode.sv
// Combinational instruction decode: write enable, rd, load flag and which
// source registers the instruction actually reads.
module regwen_decode
    import regwen_tracker_pkg::*;
#(
    parameter int unsigned NREG        = 32,
    parameter int unsigned HAS_CSR     = 0,
    parameter int unsigned SUPPRESS_X0 = 1
) (
    input  logic [31:0]               inst_i,
    output logic                      wen_o,
    output logic [$clog2(NREG)-1:0]   rd_o,
    output logic [$clog2(NREG)-1:0]   rs1_o,
    output logic [$clog2(NREG)-1:0]   rs2_o,
    output logic                      is_load_o,
    output logic                      rs1_used_o,
    output logic                      rs2_used_o
);

    localparam int unsigned RW = $clog2(NREG);

    opcode_e opc;
    logic    writes;
    logic    unused_inst;

    assign opc         = opcode_e'(inst_i[6:0]);
    assign rd_o        = inst_i[7 +: RW];
    assign rs1_o       = inst_i[15 +: RW];
    assign rs2_o       = inst_i[20 +: RW];
    assign is_load_o   = (opc == OPC_LOAD);
    assign unused_inst = ^inst_i;

    always_comb begin
        writes     = RegWEn_READ;
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b0;
        case (opc)
            OPC_OP: begin
                writes     = RegWEn_WRITE;
                rs2_used_o = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: writes = RegWEn_WRITE;
            OPC_JAL, OPC_AUIPC, OPC_LUI: begin
                writes     = RegWEn_WRITE;
                rs1_used_o = 1'b0;
            end
            OPC_SYSTEM: writes = (HAS_CSR != 0) && (inst_i[14:12] != FUNCT3_CSR_PRIV);
            OPC_STORE, OPC_BRANCH: rs2_used_o = 1'b1;
            default: ;
        endcase
    end

    assign wen_o = writes & ~((SUPPRESS_X0 != 0) && (rd_o == '0));

endmodule

// File: rtl/regwen_tracker.sv
// Issue-to-writeback write-enable pipeline with per-register pending-write
// counters, exporting busy, load-use hazard and in-flight writer count.
module regwen_tracker
    import regwen_tracker_pkg::*;
#(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned NREG        = 32,
    parameter int unsigned HAS_CSR     = 0,
    parameter int unsigned SUPPRESS_X0 = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_valid,
    input  logic [31:0]                  issue_inst,
    input  logic                         stall,
    input  logic                         flush,
    output logic                         wb_wen,
    output logic [$clog2(NREG)-1:0]      wb_rd,
    output logic [NREG-1:0]              busy,
    output logic                         load_use,
    output logic [$clog2(DEPTH+1)-1:0]   inflight
);

    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v_q, v_d, wen_q, wen_d, ld_q, ld_d;
    logic [RW-1:0]    rd_q [DEPTH];
    logic [RW-1:0]    rd_d [DEPTH];
    logic [CW-1:0]    pend_q [NREG];
    logic [CW-1:0]    pend_d [NREG];
    logic [NREG-1:0]  pend_err;
    logic [CW-1:0]    inflight_q, inflight_d;

    logic             iss_wen, iss_ld, iss_rs1_used, iss_rs2_used;
    logic [RW-1:0]    iss_rd, iss_rs1, iss_rs2;
    logic             unused_ld;

    regwen_decode #(
        .NREG        (NREG),
        .HAS_CSR     (HAS_CSR),
        .SUPPRESS_X0 (SUPPRESS_X0)
    ) u_issue_dec (
        .inst_i     (issue_inst),
        .wen_o      (iss_wen),
        .rd_o       (iss_rd),
        .rs1_o      (iss_rs1),
        .rs2_o      (iss_rs2),
        .is_load_o  (iss_ld),
        .rs1_used_o (iss_rs1_used),
        .rs2_used_o (iss_rs2_used)
    );

    // Flush masks valid as entries shift, so the W slot refills with a bubble
    // while its current occupant still retires; under stall only 0..DEPTH-2 clear.
    always_comb begin
        v_d   = v_q;
        wen_d = wen_q;
        ld_d  = ld_q;
        rd_d  = rd_q;
        if (!stall) begin
            v_d[0]   = issue_valid & ~flush;
            wen_d[0] = iss_wen;
            ld_d[0]  = iss_ld;
            rd_d[0]  = iss_rd;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                v_d[i]   = v_q[i-1] & ~flush;
                wen_d[i] = wen_q[i-1];
                ld_d[i]  = ld_q[i-1];
                rd_d[i]  = rd_q[i-1];
            end
        end else if (flush) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                v_d[i] = 1'b0;
            end
        end
    end

    assign wb_wen    = v_q[DEPTH-1] & wen_q[DEPTH-1] & ~stall;
    assign wb_rd     = rd_q[DEPTH-1];
    assign unused_ld = ld_q[DEPTH-1];

    always_comb begin
        int nxt;
        nxt      = 0;
        pend_err = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            nxt = int'(pend_q[r]);
            if (!stall && issue_valid && !flush && iss_wen && (iss_rd == RW'(r))) nxt++;
            if (wb_wen && (rd_q[DEPTH-1] == RW'(r))) nxt--;
            if (flush) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    if (v_q[i] && wen_q[i] && (rd_q[i] == RW'(r))) nxt--;
                end
            end
            pend_err[r] = (nxt < 0) || (nxt > int'(DEPTH));
            pend_d[r]   = nxt[CW-1:0];
        end
    end

    always_comb begin
        inflight_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            inflight_d = inflight_d + CW'(v_d[i] & wen_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q        <= '0;
            wen_q      <= '0;
            ld_q       <= '0;
            inflight_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) rd_q[i] <= '0;
            for (int unsigned r = 0; r < NREG; r++) pend_q[r] <= '0;
        end else begin
            v_q        <= v_d;
            wen_q      <= wen_d;
            ld_q       <= ld_d;
            inflight_q <= inflight_d;
            for (int unsigned i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
            for (int unsigned r = 0; r < NREG; r++) pend_q[r] <= pend_d[r];
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) pend_err == '0);

    always_comb begin
        busy = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            busy[r] = |pend_q[r];
        end
        if (SUPPRESS_X0 != 0) busy[0] = 1'b0;
    end

    assign inflight = inflight_q;

    assign load_use = v_q[0] & ld_q[0] & wen_q[0] & issue_valid & (rd_q[0] != '0) &
                      ((iss_rs1_used & (iss_rs1 == rd_q[0])) |
                       (iss_rs2_used & (iss_rs2 == rd_q[0])));

endmodule

// File: tb/tb_regwen_tracker.sv
// Directed bench for regwen_tracker: DEPTH=2, DEPTH=3 and a CSR-enabled
// instance share one stimulus stream; each task checks the instance it targets.
module tb_regwen_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [31:0] issue_inst;
    logic        stall;
    logic        flush;

    logic        wen2, wen3, wenc;
    logic [4:0]  rd2, rd3, rdc;
    logic [31:0] busy2, busy3, busyc;
    logic        lu2, lu3, luc;
    logic [1:0]  inf2, inf3, infc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regwen_tracker #(.DEPTH(2), .NREG(32), .HAS_CSR(0), .SUPPRESS_X0(1)) u2 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_inst(issue_inst),
        .stall(stall), .flush(flush), .wb_wen(wen2), .wb_rd(rd2), .busy(busy2),
        .load_use(lu2), .inflight(inf2));

    regwen_tracker #(.DEPTH(3), .NREG(32), .HAS_CSR(0), .SUPPRESS_X0(1)) u3 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_inst(issue_inst),
        .stall(stall), .flush(flush), .wb_wen(wen3), .wb_rd(rd3), .busy(busy3),
        .load_use(lu3), .inflight(inf3));

    regwen_tracker #(.DEPTH(2), .NREG(32), .HAS_CSR(1), .SUPPRESS_X0(1)) uc (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_inst(issue_inst),
        .stall(stall), .flush(flush), .wb_wen(wenc), .wb_rd(rdc), .busy(busyc),
        .load_use(luc), .inflight(infc));

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] i_alu(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd5, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] load(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] store(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction
    function automatic logic [31:0] system(input logic [4:0] rd, input logic [2:0] f3);
        return {12'h300, 5'd1, f3, rd, 7'b1110011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        issue_valid = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; issue_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        issue_inst = 32'h0000_0013;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        checks++; if ({wen2, rd2, busy2, lu2, inf2} !== '0) begin errors++;
            $display("FAIL reset_d2: got wen=%b rd=%0d busy=%h lu=%b inf=%0d, want all 0", wen2, rd2, busy2, lu2, inf2); end
        checks++; if ({wen3, rd3, busy3, lu3, inf3} !== '0) begin errors++;
            $display("FAIL reset_d3: got wen=%b rd=%0d busy=%h lu=%b inf=%0d, want all 0", wen3, rd3, busy3, lu3, inf3); end
        checks++; if ({wenc, rdc, busyc, luc, infc} !== '0) begin errors++;
            $display("FAIL reset_csr: got wen=%b rd=%0d busy=%h lu=%b inf=%0d, want all 0", wenc, rdc, busyc, luc, infc); end
    endtask

    task automatic test_basic();
        issue_valid = 1'b1; issue_inst = r_type(5, 1, 2);
        #1; step();
        issue_inst = store(5, 1);
        #1;
        checks++; if (wen2 !== 1'b0) begin errors++; $display("FAIL basic_wen_e1: got %b want 0", wen2); end
        checks++; if (busy2[5] !== 1'b1) begin errors++; $display("FAIL basic_busy_e1: got %b want 1", busy2[5]); end
        checks++; if (inf2 !== 2'd1) begin errors++; $display("FAIL basic_inf_e1: got %0d want 1", inf2); end
        step();
        issue_valid = 1'b0;
        #1;
        checks++; if (wen2 !== 1'b1 || rd2 !== 5'd5) begin errors++; $display("FAIL basic_wb: got wen=%b rd=%0d want wen=1 rd=5", wen2, rd2); end
        checks++; if (busy2[5] !== 1'b1) begin errors++; $display("FAIL basic_busy_e2: got %b want 1", busy2[5]); end
        checks++; if (inf2 !== 2'd1) begin errors++; $display("FAIL basic_inf_e2: got %0d want 1", inf2); end
        step();
        checks++; if (wen2 !== 1'b0) begin errors++; $display("FAIL basic_store_wen: got %b want 0", wen2); end
        checks++; if (busy2[5] !== 1'b0) begin errors++; $display("FAIL basic_busy_e3: got %b want 0", busy2[5]); end
        checks++; if (inf2 !== 2'd0) begin errors++; $display("FAIL basic_inf_e3: got %0d want 0", inf2); end
        step();
        checks++; if (wen2 !== 1'b0) begin errors++; $display("FAIL basic_wen_e4: got %b want 0", wen2); end
        idle(3);
    endtask

    task automatic test_load_use();
        issue_valid = 1'b1; issue_inst = load(7, 1);
        #1; step();
        issue_inst = r_type(8, 7, 1); #1;
        checks++; if (lu2 !== 1'b1) begin errors++; $display("FAIL lu_rs1: got %b want 1", lu2); end
        checks++; if (lu3 !== 1'b1) begin errors++; $display("FAIL lu_rs1_d3: got %b want 1", lu3); end
        issue_inst = r_type(8, 1, 7); #1;
        checks++; if (lu2 !== 1'b1) begin errors++; $display("FAIL lu_rs2: got %b want 1", lu2); end
        issue_inst = r_type(8, 9, 1); #1;
        checks++; if (lu2 !== 1'b0) begin errors++; $display("FAIL lu_nomatch: got %b want 0", lu2); end
        issue_inst = {20'd7, 5'd8, 7'b0110111}; #1;
        checks++; if (lu2 !== 1'b0) begin errors++; $display("FAIL lu_lui: got %b want 0", lu2); end
        issue_inst = store(7, 1); #1;
        checks++; if (lu2 !== 1'b1) begin errors++; $display("FAIL lu_store_rs2: got %b want 1", lu2); end
        issue_inst = i_alu(8, 1); #1;
        checks++; if (lu2 !== 1'b0) begin errors++; $display("FAIL lu_imm_no_rs2: got %b want 0", lu2); end
        issue_inst = r_type(8, 7, 1); stall = 1'b1; #1;
        checks++; if (lu2 !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", lu2); end
        issue_valid = 1'b0; #1;
        checks++; if (lu2 !== 1'b0) begin errors++; $display("FAIL lu_novalid: got %b want 0", lu2); end
        idle(3);
        issue_valid = 1'b1; issue_inst = load(0, 1);
        #1; step();
        issue_inst = r_type(8, 0, 0); #1;
        checks++; if (lu2 !== 1'b0) begin errors++; $display("FAIL lu_x0: got %b want 0", lu2); end
        idle(3);
    endtask

    task automatic test_stall();
        issue_valid = 1'b1; issue_inst = i_alu(3, 1);
        #1; step();
        issue_valid = 1'b0;
        #1; step();
        checks++; if (wen2 !== 1'b1 || rd2 !== 5'd3) begin errors++; $display("FAIL stall_pre: got wen=%b rd=%0d want 1/3", wen2, rd2); end
        stall = 1'b1; #1;
        checks++; if (wen2 !== 1'b0) begin errors++; $display("FAIL stall_gate: got %b want 0", wen2); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (wen2 !== 1'b0 || rd2 !== 5'd3) begin errors++; $display("FAIL stall_hold%0d: got wen=%b rd=%0d want 0/3", k, wen2, rd2); end
            checks++; if (busy2[3] !== 1'b1 || inf2 !== 2'd1) begin errors++; $display("FAIL stall_busy%0d: got busy=%b inf=%0d want 1/1", k, busy2[3], inf2); end
        end
        stall = 1'b0; #1;
        checks++; if (wen2 !== 1'b1 || rd2 !== 5'd3) begin errors++; $display("FAIL stall_release: got wen=%b rd=%0d want 1/3", wen2, rd2); end
        step();
        checks++; if (wen2 !== 1'b0 || busy2[3] !== 1'b0 || inf2 !== 2'd0) begin errors++;
            $display("FAIL stall_after: got wen=%b busy=%b inf=%0d want 0/0/0", wen2, busy2[3], inf2); end
        idle(3);
    endtask

    task automatic test_flush_depth3();
        issue_valid = 1'b1; issue_inst = r_type(4, 1, 2);
        repeat (3) step();
        checks++; if (inf3 !== 2'd3 || busy3[4] !== 1'b1) begin errors++; $display("FAIL flush3_full: got inf=%0d busy=%b want 3/1", inf3, busy3[4]); end
        flush = 1'b1; #1;
        checks++; if (wen3 !== 1'b1 || rd3 !== 5'd4) begin errors++; $display("FAIL flush3_wb: got wen=%b rd=%0d want 1/4", wen3, rd3); end
        step();
        flush = 1'b0; issue_valid = 1'b0; #1;
        checks++; if (wen3 !== 1'b0 || busy3[4] !== 1'b0 || inf3 !== 2'd0) begin errors++;
            $display("FAIL flush3_after: got wen=%b busy=%b inf=%0d want 0/0/0", wen3, busy3[4], inf3); end
        step();
        checks++; if (wen3 !== 1'b0) begin errors++; $display("FAIL flush3_nowrite: got %b want 0", wen3); end
        idle(3);
    endtask

    task automatic test_flush_stall();
        issue_valid = 1'b1; issue_inst = r_type(6, 1, 2);
        #1; step();
        issue_inst = r_type(7, 1, 2);
        #1; step();
        issue_valid = 1'b0; flush = 1'b1; stall = 1'b1; #1;
        checks++; if (wen2 !== 1'b0) begin errors++; $display("FAIL fs_gate: got %b want 0", wen2); end
        step();
        flush = 1'b0; stall = 1'b0; #1;
        checks++; if (busy2[7] !== 1'b0 || busy2[6] !== 1'b1 || inf2 !== 2'd1) begin errors++;
            $display("FAIL fs_kill: got busy7=%b busy6=%b inf=%0d want 0/1/1", busy2[7], busy2[6], inf2); end
        checks++; if (wen2 !== 1'b1 || rd2 !== 5'd6) begin errors++; $display("FAIL fs_wb: got wen=%b rd=%0d want 1/6", wen2, rd2); end
        step();
        checks++; if (inf2 !== 2'd0 || busy2[6] !== 1'b0) begin errors++; $display("FAIL fs_after: got inf=%0d busy6=%b want 0/0", inf2, busy2[6]); end
        idle(3);
    endtask

    task automatic test_csr();
        issue_valid = 1'b1; issue_inst = system(10, 3'b001);
        #1; step();
        issue_valid = 1'b0; #1;
        checks++; if (busyc[10] !== 1'b1 || infc !== 2'd1) begin errors++; $display("FAIL csr_busy: got busy=%b inf=%0d want 1/1", busyc[10], infc); end
        checks++; if (busy2[10] !== 1'b0 || inf2 !== 2'd0) begin errors++; $display("FAIL csr_off_busy: got busy=%b inf=%0d want 0/0", busy2[10], inf2); end
        step();
        checks++; if (wenc !== 1'b1 || rdc !== 5'd10) begin errors++; $display("FAIL csr_wb: got wen=%b rd=%0d want 1/10", wenc, rdc); end
        checks++; if (wen2 !== 1'b0) begin errors++; $display("FAIL csr_off_wb: got %b want 0", wen2); end
        step();
        checks++; if (wenc !== 1'b0 || busyc[10] !== 1'b0) begin errors++; $display("FAIL csr_after: got wen=%b busy=%b want 0/0", wenc, busyc[10]); end
        issue_valid = 1'b1; issue_inst = system(10, 3'b000);
        #1; step();
        issue_valid = 1'b0; #1;
        checks++; if (infc !== 2'd0 || busyc[10] !== 1'b0) begin errors++; $display("FAIL priv_busy: got inf=%0d busy=%b want 0/0", infc, busyc[10]); end
        step();
        checks++; if (wenc !== 1'b0) begin errors++; $display("FAIL priv_wb: got %b want 0", wenc); end
        idle(3);
    endtask

    task automatic test_reset_midflight();
        issue_valid = 1'b1; issue_inst = r_type(5, 1, 2);
        #1; step();
        issue_inst = r_type(6, 1, 2);
        #1; step();
        issue_valid = 1'b0; #1;
        checks++; if (inf2 !== 2'd2) begin errors++; $display("FAIL rst_mid_pre: got inf=%0d want 2", inf2); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; #1;
        checks++; if (wen2 !== 1'b0 || busy2 !== 32'd0 || inf2 !== 2'd0 || rd2 !== 5'd0) begin errors++;
            $display("FAIL rst_mid: got wen=%b busy=%h inf=%0d rd=%0d want all 0", wen2, busy2, inf2, rd2); end
        issue_valid = 1'b1; issue_inst = r_type(9, 1, 2);
        #1; step();
        issue_valid = 1'b0; #1;
        step();
        checks++; if (wen2 !== 1'b1 || rd2 !== 5'd9) begin errors++; $display("FAIL rst_mid_resume: got wen=%b rd=%0d want 1/9", wen2, rd2); end
        step();
        checks++; if (wen2 !== 1'b0 || busy2 !== 32'd0) begin errors++; $display("FAIL rst_mid_drain: got wen=%b busy=%h want 0/0", wen2, busy2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_use();
        test_stall();
        test_flush_depth3();
        test_flush_stall();
        test_csr();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "time limit");
    end

endmodule
